bitwindow_rd: RTL and testbench

BITWINDOW_RD -- requirements
Module: bitwindow_rd

---
 rtl/bitwindow_rd.sv | 120 ++++++++++++
 tb/tb_bitwindow_rd.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bitwindow_rd.sv
// Bit-window reader: pulls 32-bit words from a common-clock fifo into a
// left-justified 64-bit buffer and presents the next 24 stream bits, with
// variable-length consume, byte-align, flush and a sticky protocol-error flag.
module bitwindow_rd (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] fifo_dout,
    input  logic        fifo_valid,
    input  logic        fifo_empty,
    output logic        fifo_rd_en,
    output logic [23:0] getbits,
    output logic        window_valid,
    input  logic [4:0]  advance,
    input  logic        advance_en,
    input  logic        align_en,
    input  logic        flush,
    output logic        err
);

    localparam int unsigned BUF_W  = 64;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned WIN_W  = 24;
    localparam int unsigned FILL_W = 7;
    localparam int unsigned CNT_W  = 5;

    logic [BUF_W-1:0]  buf_q;
    logic [FILL_W-1:0] fill_q;
    logic              pend_q;
    logic [2:0]        bitpos_q;
    logic              err_q;
    logic              wv_q;
    logic              drop_q;

    logic [CNT_W-1:0]  consume;
    logic              err_set;
    logic              accept;
    logic              spurious;
    logic [FILL_W-1:0] room;
    logic [BUF_W-1:0]  buf_n;
    logic [FILL_W-1:0] fill_n;

    // Request a word only when the whole word is guaranteed to fit
    always_comb begin
        fifo_rd_en = rst && !fifo_empty && !pend_q && !flush
                     && (fill_q <= FILL_W'(WORD_W));
    end

    // Consume amount and error detection for advance/align requests
    always_comb begin
        consume = '0;
        err_set = 1'b0;
        if (advance_en) begin
            if (!wv_q || (advance > CNT_W'(WIN_W))) begin
                err_set = 1'b1;
            end else begin
                consume = advance;
            end
            if (align_en) begin
                err_set = 1'b1;
            end
        end else if (align_en) begin
            if (!wv_q) begin
                err_set = 1'b1;
            end else begin
                consume = CNT_W'(3'(3'd0 - bitpos_q));
            end
        end
    end

    // Shift out consumed bits, then append any returned word behind the rest
    always_comb begin
        spurious = fifo_valid && !drop_q && !pend_q;
        accept   = fifo_valid && !drop_q && (pend_q || (fill_q <= FILL_W'(WORD_W)));
        room     = fill_q - FILL_W'(consume);
        buf_n    = buf_q << consume;
        fill_n   = room;
        if (accept) begin
            buf_n  = buf_n | ({fifo_dout, WORD_W'(0)} >> room);
            fill_n = room + FILL_W'(WORD_W);
        end
    end

    // State update; reset beats flush, flush beats consume/append
    always_ff @(posedge clk) begin
        if (!rst) begin
            buf_q    <= '0;
            fill_q   <= '0;
            pend_q   <= 1'b0;
            bitpos_q <= '0;
            err_q    <= 1'b0;
            wv_q     <= 1'b0;
            drop_q   <= 1'b1;
        end else if (flush) begin
            buf_q    <= '0;
            fill_q   <= '0;
            pend_q   <= 1'b0;
            bitpos_q <= '0;
            wv_q     <= 1'b0;
            drop_q   <= 1'b1;
        end else begin
            buf_q    <= buf_n;
            fill_q   <= fill_n;
            pend_q   <= fifo_rd_en;
            bitpos_q <= bitpos_q + 3'(consume);
            wv_q     <= (fill_n >= FILL_W'(WIN_W));
            drop_q   <= 1'b0;
            if (err_set || spurious) begin
                err_q <= 1'b1;
            end
        end
    end

    // Outputs come straight from state registers
    always_comb begin
        getbits      = buf_q[BUF_W-1 -: WIN_W];
        window_valid = wv_q;
        err          = err_q;
    end

endmodule

// File: tb/tb_bitwindow_rd.sv
// Bench for bitwindow_rd: directed scenarios plus a randomized run checked
// by a scoreboard fed from a bit-stream reference model.
module tb_bitwindow_rd;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] fifo_dout;
    logic        fifo_valid;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic [23:0] getbits;
    logic        window_valid;
    logic [4:0]  advance;
    logic        advance_en;
    logic        align_en;
    logic        flush;
    logic        err;

    bitwindow_rd dut (
        .clk          (clk),
        .rst          (rst),
        .fifo_dout    (fifo_dout),
        .fifo_valid   (fifo_valid),
        .fifo_empty   (fifo_empty),
        .fifo_rd_en   (fifo_rd_en),
        .getbits      (getbits),
        .window_valid (window_valid),
        .advance      (advance),
        .advance_en   (advance_en),
        .align_en     (align_en),
        .flush        (flush),
        .err          (err)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;

    // directed controls
    logic        d_rst = 1'b0;
    logic [4:0]  d_adv = '0;
    logic        d_adv_en = 1'b0;
    logic        d_align = 1'b0;
    logic        d_flush = 1'b0;
    logic        stall = 1'b0;
    logic        inj_valid = 1'b0;
    logic [31:0] inj_word = '0;

    // fifo model
    logic [31:0] src_q[$];
    logic        rd_issued = 1'b0;
    logic [31:0] pend_word = '0;

    // reference model and scoreboard
    bit          rnd_mode = 1'b0;
    bit          sb_on = 1'b0;
    bit          ref_bits[$];
    int unsigned consumed = 0;
    logic [23:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    task automatic push_word(input logic [31:0] w);
        src_q.push_back(w);
        if (rnd_mode) begin
            for (int i = 31; i >= 0; i--) ref_bits.push_back(w[i]);
        end
    endtask

    // one clock: drive at negedge, capture the read request, settle after posedge
    task automatic step();
        int r;
        int c;
        logic [23:0] e;
        @(negedge clk);
        if (rnd_mode) begin
            while (src_q.size() < 3) push_word($urandom);
            stall    = ($urandom_range(0, 3) == 0);
            d_adv_en = 1'b0;
            d_align  = 1'b0;
            d_adv    = '0;
            c        = 0;
            if (window_valid) begin
                r = $urandom_range(0, 9);
                if (r < 6) begin
                    d_adv_en = 1'b1;
                    d_adv    = 5'($urandom_range(0, 24));
                    c        = int'(d_adv);
                end else if (r < 8) begin
                    d_align = 1'b1;
                    c       = int'((8 - (consumed % 8)) % 8);
                end
                if (d_adv_en || d_align) begin
                    if (ref_bits.size() < 24) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL model_underrun: got %0d bits expected >= 24", ref_bits.size());
                    end else begin
                        e = '0;
                        for (int i = 0; i < 24; i++) e = {e[22:0], ref_bits[i]};
                        exp_q.push_back(e);
                        for (int i = 0; i < c; i++) void'(ref_bits.pop_front());
                        consumed += c;
                    end
                end
            end
        end
        fifo_valid = rd_issued | inj_valid;
        fifo_dout  = inj_valid ? inj_word : pend_word;
        fifo_empty = (src_q.size() == 0) || stall;
        advance    = d_adv;
        advance_en = d_adv_en;
        align_en   = d_align;
        flush      = d_flush;
        rst        = d_rst;
        #1;
        rd_issued = fifo_rd_en;
        if (rd_issued) pend_word = src_q.pop_front();
        @(posedge clk);
        #1;
    endtask

    task automatic ctl(input logic [4:0] a, input logic ae, input logic al, input logic fl);
        d_adv    = a;
        d_adv_en = ae;
        d_align  = al;
        d_flush  = fl;
    endtask

    task automatic do_reset();
        d_rst = 1'b0;
        ctl(5'd0, 1'b0, 1'b0, 1'b0);
        step();
        step();
        d_rst = 1'b1;
    endtask

    // scoreboard monitor: a consume handshake presents the pre-consume window
    always begin
        @(negedge clk);
        #2;
        if (sb_on && rst && !flush && (advance_en || align_en) && window_valid) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL sb_empty: got window 0x%0h with no expectation", getbits);
            end else begin
                chk("sb_window", 32'(getbits), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        rst = 1'b0; fifo_dout = '0; fifo_valid = 1'b0; fifo_empty = 1'b1;
        advance = '0; advance_en = 1'b0; align_en = 1'b0; flush = 1'b0;

        // reset with a loaded fifo: no reads, clean outputs
        push_word(32'h1234_5678);
        push_word(32'h9ABC_DEF0);
        d_rst = 1'b0;
        step();
        chk("rst_rd_en", 32'(rd_issued), 32'h0);
        step();
        chk("rst_rd_en2", 32'(rd_issued), 32'h0);
        chk("rst_getbits", 32'(getbits), 32'h0);
        chk("rst_wv", 32'(window_valid), 32'h0);
        chk("rst_err", 32'(err), 32'h0);

        // two words fill the buffer; reads pace at one per two cycles
        d_rst = 1'b1;
        step();
        chk("s1_rd", 32'(rd_issued), 32'h1);
        step();
        chk("s2_wv", 32'(window_valid), 32'h1);
        chk("s2_getbits", 32'(getbits), 32'h123456);
        chk("s2_rd", 32'(rd_issued), 32'h0);
        step();
        chk("s3_rd", 32'(rd_issued), 32'h1);
        step();
        chk("s4_getbits", 32'(getbits), 32'h123456);
        push_word(32'hA5C3_0F96);
        step();
        chk("full_rd", 32'(rd_issued), 32'h0);

        // advance 4 then align
        ctl(5'd4, 1'b1, 1'b0, 1'b0); step();
        chk("adv4", 32'(getbits), 32'h234567);
        chk("adv4_rd", 32'(rd_issued), 32'h0);
        ctl(5'd0, 1'b0, 1'b1, 1'b0); step();
        chk("align", 32'(getbits), 32'h345678);
        ctl(5'd0, 1'b1, 1'b0, 1'b0); step();
        chk("adv0", 32'(getbits), 32'h345678);
        ctl(5'd0, 1'b0, 1'b1, 1'b0); step();
        chk("align_noop", 32'(getbits), 32'h345678);
        chk("noop_err", 32'(err), 32'h0);

        // drain to fill=32, then consume while a word lands
        ctl(5'd24, 1'b1, 1'b0, 1'b0); step();
        chk("adv24", 32'(getbits), 32'h9ABCDE);
        ctl(5'd8, 1'b1, 1'b0, 1'b0); step();
        chk("adv8_rd", 32'(rd_issued), 32'h1);
        chk("adv8", 32'(getbits), 32'hBCDEF0);
        ctl(5'd24, 1'b1, 1'b0, 1'b0); step();
        chk("cons_app", 32'(getbits), 32'hA5C30F);
        chk("cons_app_wv", 32'(window_valid), 32'h1);
        chk("cons_app_err", 32'(err), 32'h0);

        // illegal advance
        ctl(5'd25, 1'b1, 1'b0, 1'b0); step();
        chk("adv25", 32'(getbits), 32'hA5C30F);
        chk("adv25_err", 32'(err), 32'h1);
        ctl(5'd0, 1'b0, 1'b0, 1'b1); step();
        chk("flush_err", 32'(err), 32'h1);
        chk("flush_wv", 32'(window_valid), 32'h0);
        ctl(5'd0, 1'b0, 1'b0, 1'b0);

        // flush right after a read: returned word discarded silently
        do_reset();
        push_word(32'h1122_3344);
        step();
        chk("f_rd", 32'(rd_issued), 32'h1);
        ctl(5'd0, 1'b0, 1'b0, 1'b1); step();
        ctl(5'd0, 1'b0, 1'b0, 1'b0); step();
        chk("f_wv", 32'(window_valid), 32'h0);
        chk("f_getbits", 32'(getbits), 32'h0);
        chk("f_err", 32'(err), 32'h0);

        // unsolicited word: flagged but still appended
        inj_valid = 1'b1; inj_word = 32'hCAFE_BABE;
        step();
        inj_valid = 1'b0;
        chk("spur_err", 32'(err), 32'h1);
        chk("spur_getbits", 32'(getbits), 32'hCAFEBA);
        chk("spur_wv", 32'(window_valid), 32'h1);

        // consume with no valid window
        do_reset();
        ctl(5'd4, 1'b1, 1'b0, 1'b0); step();
        chk("nowin_err", 32'(err), 32'h1);
        chk("nowin_getbits", 32'(getbits), 32'h0);

        // randomized run against the bit-stream model
        src_q.delete();
        do_reset();
        ref_bits.delete();
        consumed = 0;
        rnd_mode = 1'b1;
        sb_on    = 1'b1;
        for (int k = 0; k < 10000; k++) step();
        rnd_mode = 1'b0;
        stall    = 1'b1;
        ctl(5'd0, 1'b0, 1'b0, 1'b0);
        step();
        sb_on = 1'b0;
        chk("rnd_err", 32'(err), 32'h0);
        chk("rnd_sb_left", 32'(exp_q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
